// File: rtl/scrambler_pkg.sv
// Shared constants for the x^7+x^4+1 (802.11) scrambler.
// Reseed-on-last behaviour is selected in the top with SCRAMBLER_RESEED_ON_LAST_EN.
package scrambler_pkg;

  localparam int LFSR_LEN = 7;
  localparam int TAP_HI   = 6;
  localparam int TAP_LO   = 3;

  localparam logic [LFSR_LEN-1:0] DEFAULT_SEED = 7'b1011101;

  // One serial LFSR step: returns {feedback bit, next state}.
  function automatic logic [LFSR_LEN:0] lfsr_step(input logic [LFSR_LEN-1:0] s);
    logic fb;
    fb = s[TAP_HI] ^ s[TAP_LO];
    return {fb, s[LFSR_LEN-2:0], fb};
  endfunction

endpackage

// File: rtl/scrambler_lfsr.sv
// Combinational WIDTH-step unroll of the scrambler LFSR.
// keystream[0] is the first bit in time, keystream[WIDTH-1] the last.
module scrambler_lfsr
  import scrambler_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic [LFSR_LEN-1:0] state,
  output logic [WIDTH-1:0]    keystream,
  output logic [LFSR_LEN-1:0] next_state
);

  logic [LFSR_LEN-1:0] walk;
  logic [LFSR_LEN:0]   step;

  always_comb begin
    keystream = '0;
    walk      = state;
    step      = '0;
    for (int i = 0; i < WIDTH; i++) begin
      step         = lfsr_step(walk);
      keystream[i] = step[LFSR_LEN];
      walk         = step[LFSR_LEN-1:0];
    end
    next_state = walk;
  end

endmodule

// File: rtl/scrambler.sv
// AXI-Stream additive scrambler with a single output register stage.
// Define SCRAMBLER_RESEED_ON_LAST_EN to reload the seed after every tlast beat.
module scrambler
  import scrambler_pkg::*;
#(
  parameter int                  WIDTH = 24,
  parameter logic [LFSR_LEN-1:0] SEED  = DEFAULT_SEED
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [WIDTH-1:0] s_axis_tdata,
  input  logic [3:0]       s_axis_tuser,
  input  logic             s_axis_tlast,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  output logic [WIDTH-1:0] m_axis_tdata,
  output logic [3:0]       m_axis_tuser,
  output logic             m_axis_tlast,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready
);

  // Handshake: a beat transfers on a rising edge where valid and ready are
  // both high; valid never depends on ready, ready may depend on valid.
  logic [LFSR_LEN-1:0] lfsr_state;
  logic [LFSR_LEN-1:0] lfsr_next;
  logic [WIDTH-1:0]    keystream;
  logic                in_xfer;

  assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
  assign in_xfer       = s_axis_tvalid && s_axis_tready;

  scrambler_lfsr #(.WIDTH(WIDTH)) u_lfsr (
    .state      (lfsr_state),
    .keystream  (keystream),
    .next_state (lfsr_next)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      lfsr_state    <= SEED;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b0;
    end else begin
      if (in_xfer) begin
`ifdef SCRAMBLER_RESEED_ON_LAST_EN
        lfsr_state <= s_axis_tlast ? SEED : lfsr_next;
`else
        lfsr_state <= lfsr_next;
`endif
        m_axis_tdata  <= s_axis_tdata ^ keystream;
        m_axis_tuser  <= s_axis_tuser;
        m_axis_tlast  <= s_axis_tlast;
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_scrambler.sv
// Scoreboard bench for scrambler: driver pushes expected beats, negedge monitor pops.
// Honours SCRAMBLER_RESEED_ON_LAST_EN in its reference model.
module tb_scrambler;

  localparam int             WIDTH = 24;
  localparam int             EW    = WIDTH + 5;
  localparam logic [6:0]     SEED  = 7'b1011101;
  localparam logic [WIDTH-1:0] FIRST_WORD = 24'h959836;

  logic             aclk;
  logic             aresetn;
  logic [WIDTH-1:0] s_axis_tdata;
  logic [3:0]       s_axis_tuser;
  logic             s_axis_tlast;
  logic             s_axis_tvalid;
  logic             s_axis_tready;
  logic [WIDTH-1:0] m_axis_tdata;
  logic [3:0]       m_axis_tuser;
  logic             m_axis_tlast;
  logic             m_axis_tvalid;
  logic             m_axis_tready;

  int n_checks = 0;
  int n_fail   = 0;

  logic [EW-1:0]    exp_q[$];
  logic [WIDTH-1:0] cap_q[$];
  logic [6:0]       model_s;
  logic [EW-1:0]    mon_e;

  scrambler #(.WIDTH(WIDTH), .SEED(SEED)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
  );

  // Clock and reset
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Bit-serial reference: fb = s[6]^s[3], bit 0 first.
  task automatic model_push(input logic [WIDTH-1:0] d, input logic [3:0] u, input logic l);
    logic [WIDTH-1:0] w;
    logic fb;
    for (int i = 0; i < WIDTH; i++) begin
      fb      = model_s[6] ^ model_s[3];
      w[i]    = d[i] ^ fb;
      model_s = {model_s[5:0], fb};
    end
`ifdef SCRAMBLER_RESEED_ON_LAST_EN
    if (l) model_s = SEED;
`endif
    exp_q.push_back({l, u, w});
  endtask

  task automatic apply_reset();
    aresetn = 1'b0;
    exp_q.delete();
    cap_q.delete();
    model_s = SEED;
    @(negedge aclk);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_tuser", m_axis_tuser, 0);
    check("rst_tlast", m_axis_tlast, 0);
    @(posedge aclk);
    #1 aresetn = 1'b1;
  endtask

  // Driver: called just after a rising edge, returns just after the accepting edge.
  task automatic send_beat(input logic [WIDTH-1:0] d, input logic [3:0] u, input logic l,
                           output int waited);
    s_axis_tdata  = d;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    waited = 0;
    forever begin
      @(negedge aclk);
      if (s_axis_tready) break;
      waited++;
      if (waited > 50) begin
        check("accept_timeout", waited, 0);
        s_axis_tvalid = 1'b0;
        return;
      end
    end
    @(posedge aclk);
    model_push(d, u, l);
    #1;
  endtask

  task automatic idle();
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tuser  = '0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      @(posedge aclk);
      k++;
    end
    #1;
    check("drain_pending", exp_q.size(), 0);
  endtask

  // Scoreboard monitor
  always @(negedge aclk) begin
    if (aresetn && m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", m_axis_tdata, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_tdata", m_axis_tdata, mon_e[WIDTH-1:0]);
        check("out_tuser", m_axis_tuser, mon_e[WIDTH+3:WIDTH]);
        check("out_tlast", m_axis_tlast, mon_e[EW-1]);
      end
      cap_q.push_back(m_axis_tdata);
    end
  end

  initial begin
    int w;
    int total_wait;
    logic [WIDTH-1:0] plain [10];
    logic [WIDTH-1:0] cipher [10];

    aresetn = 1'b0;
    m_axis_tready = 1'b1;
    idle();
    model_s = SEED;
    repeat (2) @(posedge aclk);
    #1;
    apply_reset();

    // Three zero beats right after reset
    for (int i = 0; i < 3; i++) send_beat('0, 4'(i), 1'b0, w);
    idle();
    drain();
    check("first_word", cap_q.size() > 0 ? cap_q[0] : '0, FIRST_WORD);

    // Backpressure: output held, input stalled
    apply_reset();
    m_axis_tready = 1'b0;
    send_beat(24'h123456, 4'h5, 1'b0, w);
    s_axis_tdata  = 24'hABCDEF;
    s_axis_tuser  = 4'hA;
    s_axis_tvalid = 1'b1;
    repeat (5) begin
      @(negedge aclk);
      check("stall_s_tready", s_axis_tready, 0);
      check("stall_m_tvalid", m_axis_tvalid, 1);
      check("stall_tdata", m_axis_tdata, exp_q[0][WIDTH-1:0]);
      check("stall_tuser", m_axis_tuser, exp_q[0][WIDTH+3:WIDTH]);
    end
    @(posedge aclk);
    #1 m_axis_tready = 1'b1;
    send_beat(24'hABCDEF, 4'hA, 1'b1, w);
    idle();
    drain();
    check("stall_first", cap_q.size() > 0 ? cap_q[0] : '0, 24'h123456 ^ FIRST_WORD);

    // Continuous throughput, 10 beats
    apply_reset();
    total_wait = 0;
    for (int i = 0; i < 10; i++) begin
      send_beat(WIDTH'($urandom()), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), w);
      total_wait += w;
    end
    idle();
    drain();
    check("stream_stalls", total_wait, 0);
    check("stream_count", cap_q.size(), 10);

    // Descramble round trip
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      plain[i] = WIDTH'($urandom());
      send_beat(plain[i], 4'(i), 1'b0, w);
    end
    idle();
    drain();
    for (int i = 0; i < 10; i++) cipher[i] = (i < cap_q.size()) ? cap_q[i] : '0;
    apply_reset();
    for (int i = 0; i < 10; i++) send_beat(cipher[i], 4'(i), 1'b0, w);
    idle();
    drain();
    for (int i = 0; i < 10; i++)
      check("roundtrip", (i < cap_q.size()) ? cap_q[i] : '0, plain[i]);

    // Reset while a beat is held
    apply_reset();
    for (int i = 0; i < 3; i++) send_beat(24'h00FF00 + WIDTH'(i), 4'(i), 1'b0, w);
    send_beat(24'h777777, 4'h3, 1'b0, w);
    m_axis_tready = 1'b0;
    idle();
    aresetn = 1'b0;
    #1;
    check("midrst_tvalid", m_axis_tvalid, 0);
    check("midrst_tdata", m_axis_tdata, 0);
    exp_q.delete();
    cap_q.delete();
    model_s = SEED;
    @(posedge aclk);
    #1 aresetn = 1'b1;
    m_axis_tready = 1'b1;
    send_beat('0, 4'h0, 1'b0, w);
    idle();
    drain();
    check("midrst_word", cap_q.size() > 0 ? cap_q[0] : '0, FIRST_WORD);

    // Frame boundary: tlast beat followed by another zero beat
    apply_reset();
    send_beat('0, 4'h1, 1'b1, w);
    send_beat('0, 4'h2, 1'b0, w);
    idle();
    drain();
    check("frame_first", cap_q.size() > 0 ? cap_q[0] : '0, FIRST_WORD);
`ifdef SCRAMBLER_RESEED_ON_LAST_EN
    check("frame_second_reseed", cap_q.size() > 1 ? cap_q[1] : '0, FIRST_WORD);
`else
    check("frame_second_differs", (cap_q.size() > 1 && cap_q[1] != FIRST_WORD) ? 1 : 0, 1);
`endif

    repeat (3) @(posedge aclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scrambler.md
SCRAMBLER -- requirements
Module: scrambler

Interface
REQ-001 Parameter WIDTH, default 24: data bits per beat, 1..64.
REQ-002 Parameter SEED, default 7'b1011101: LFSR initial state s[6:0], nonzero.
REQ-003 aclk  in  1  sole clock, rising edge.
REQ-004 aresetn  in  1  reset, asynchronous assert, active-low.
REQ-005 s_axis_tdata  in  WIDTH  plaintext beat.
REQ-006 s_axis_tuser  in  4  sideband, passed through unchanged.
REQ-007 s_axis_tlast  in  1  frame end, passed through unchanged.
REQ-008 s_axis_tvalid / s_axis_tready  in / out  1  input handshake.
REQ-009 m_axis_tdata  out  WIDTH  scrambled beat.
REQ-010 m_axis_tuser / m_axis_tlast  out  4 / 1  delayed copies of the input sideband.
REQ-011 m_axis_tvalid / m_axis_tready  out / in  1  output handshake.

Function
REQ-012 Polynomial x^7+x^4+1 (802.11): per bit, fb = s[6]^s[3]; out = in^fb; s <= {s[5:0],fb}.
REQ-013 Bit order: tdata[0] is scrambled first, tdata[WIDTH-1] last.
REQ-014 LFSR advances by exactly WIDTH steps per accepted input beat and never otherwise.
REQ-015 Single output register stage; latency 1 cycle from input acceptance to m_axis_tvalid high.
REQ-016 s_axis_tready = !m_axis_tvalid || m_axis_tready; combinational, no bubble at full throughput.
REQ-017 Output register loads tdata/tuser/tlast on input transfer; m_axis_tvalid clears on output transfer without a new input.
REQ-018 Outputs hold stable while m_axis_tvalid && !m_axis_tready.
REQ-019 Simultaneous output and input transfer in one cycle: register replaced, m_axis_tvalid stays 1.
REQ-020 Keystream is data-independent; the same block with the same SEED descrambles its own output.

Reset
REQ-021 While aresetn low: s = SEED, m_axis_tvalid = 0, m_axis_tdata = 0, m_axis_tuser = 0, m_axis_tlast = 0.
REQ-022 Reset mid-stream discards any held beat; the next accepted beat uses the keystream from SEED.

Configuration
REQ-023 Macro SCRAMBLER_RESEED_ON_LAST_EN defined: after an accepted beat with s_axis_tlast = 1, s reloads to SEED.
REQ-024 Macro undefined: tlast has no effect on the LFSR; the keystream runs continuously across frames.

Structure
REQ-025 Package scrambler_pkg: tap positions (6, 3), LFSR length 7, default seed constant.
REQ-026 Sub-module scrambler_lfsr: combinational WIDTH-step unroll; takes state, returns keystream word and next state.

Verification
REQ-027 After reset, WIDTH = 24, three zero beats with tuser 0, 1, 2 -> first beat 0x959836 (keystream 01101100 00011001 10101001, time order); tuser echoes 0, 1, 2.
REQ-028 Feed the captured output back after reset -> original plaintext recovered for 10 random beats.
REQ-029 Hold m_axis_tready = 0 for 5 cycles with the output valid -> s_axis_tready = 0; tdata/tuser stable; LFSR not advanced.
REQ-030 Continuous valid/ready for 10 beats -> one beat per cycle, outputs equal to a bit-serial reference model.
REQ-031 Assert aresetn low after beat 4 -> m_axis_tvalid = 0 at once; the next zero beat yields 0x959836.
REQ-032 With SCRAMBLER_RESEED_ON_LAST_EN: zero beat with tlast = 1, then a zero beat -> both outputs 0x959836; without the macro the second output differs.
